// File: rtl/fpu_add_normalize.sv
// Binary32 add/subtract back end: adds pre-aligned mantissas, normalizes one bit per cycle,
// rounds to nearest-even and packs the result behind valid/ready handshakes.
module fpu_add_normalize #(
    parameter int unsigned EXP_W = 10,
    parameter int unsigned MAN_W = 27,
    parameter int unsigned BIAS  = 127
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    a_s,
    input  logic                    b_s,
    input  logic signed [EXP_W-1:0] e_in,
    input  logic        [MAN_W-1:0] am_in,
    input  logic        [MAN_W-1:0] bm_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [31:0]      z
);

    typedef enum logic [2:0] {StIdle, StAdd, StNorm, StRound, StPack, StOut} state_e;

    localparam logic signed [EXP_W-1:0] EMin  = EXP_W'(-126);
    localparam logic signed [EXP_W-1:0] EMax  = EXP_W'(127);
    localparam logic signed [EXP_W-1:0] EOne  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EBias = EXP_W'(BIAS);

    state_e                  state_q, state_d;
    logic                    as_q, as_d, bs_q, bs_d;
    logic        [MAN_W-1:0] am_q, am_d, bm_q, bm_d;
    logic        [MAN_W-1:0] man_q, man_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic                    sign_q, sign_d;
    logic                    zero_q, zero_d;
    logic        [31:0]      z_q, z_d;
    logic                    out_valid_q, out_valid_d;

    logic        [MAN_W:0]   sum;
    logic        [MAN_W-3:0] rnd;

    always_comb begin
        state_d     = state_q;
        as_d        = as_q;
        bs_d        = bs_q;
        am_d        = am_q;
        bm_d        = bm_q;
        man_d       = man_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        sum         = '0;
        rnd         = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    as_d    = a_s;
                    bs_d    = b_s;
                    am_d    = am_in;
                    bm_d    = bm_in;
                    exp_d   = e_in;
                    zero_d  = 1'b0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                if (as_q == bs_q) begin
                    sum    = {1'b0, am_q} + {1'b0, bm_q};
                    sign_d = as_q;
                end else if (am_q >= bm_q) begin
                    sum    = {1'b0, am_q - bm_q};
                    sign_d = as_q;
                end else begin
                    sum    = {1'b0, bm_q - am_q};
                    sign_d = bs_q;
                end
                if (as_q != bs_q && sum == '0) begin
                    sign_d = 1'b0;
                end
                // Carry out: shift right once, folding the dropped bit into sticky.
                if (sum[MAN_W]) begin
                    man_d = {sum[MAN_W:2], sum[1] | sum[0]};
                    exp_d = exp_q + EOne;
                end else begin
                    man_d = sum[MAN_W-1:0];
                end
                state_d = StNorm;
            end
            StNorm: begin
                if (man_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = StPack;
                end else if (!man_q[MAN_W-1] && exp_q > EMin) begin
                    man_d = man_q << 1;
                    exp_d = exp_q - EOne;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                rnd = {1'b0, man_q[MAN_W-1:3]} + (MAN_W-2)'(1);
                if (man_q[2] & (man_q[1] | man_q[0] | man_q[3])) begin
                    if (rnd[MAN_W-3]) begin
                        man_d[MAN_W-1:3] = {1'b1, {(MAN_W-4){1'b0}}};
                        exp_d            = exp_q + EOne;
                    end else begin
                        man_d[MAN_W-1:3] = rnd[MAN_W-4:0];
                    end
                end
                state_d = StPack;
            end
            StPack: begin
                if (zero_q) begin
                    z_d = {sign_q, 31'b0};
                end else if (exp_q > EMax) begin
                    z_d = {sign_q, 8'hFF, 23'h0};
                end else if (exp_q == EMin && !man_q[MAN_W-1]) begin
                    z_d = {sign_q, 8'h00, man_q[MAN_W-2:3]};
                end else begin
                    z_d = {sign_q, 8'(exp_q + EBias), man_q[MAN_W-2:3]};
                end
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            as_q        <= 1'b0;
            bs_q        <= 1'b0;
            am_q        <= '0;
            bm_q        <= '0;
            man_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            as_q        <= as_d;
            bs_q        <= bs_d;
            am_q        <= am_d;
            bm_q        <= bm_d;
            man_q       <= man_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign z         = z_q;

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Bench for fpu_add_normalize: directed cases plus randomized operands against an
// arithmetic round-to-nearest-even reference.
module tb_fpu_add_normalize;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               a_s = 1'b0;
    logic               b_s = 1'b0;
    logic signed [9:0]  e_in = '0;
    logic        [26:0] am_in = '0;
    logic        [26:0] bm_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [31:0] z;

    int n_checks = 0;
    int n_errors = 0;

    fpu_add_normalize dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_s      (a_s),
        .b_s      (b_s),
        .e_in     (e_in),
        .am_in    (am_in),
        .bm_in    (bm_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: signed-magnitude sum, normalize, then RNE on the dropped bits as an integer.
    function automatic void model(input logic as, input logic bs, input int e_arg,
                                  input logic [26:0] am, input logic [26:0] bm,
                                  output logic [31:0] zz, output int lat);
        longint va, vb, tot, mag, sig, rem, half;
        int     e, k;
        logic   sgn;
        e   = e_arg;
        va  = as ? -longint'(am) : longint'(am);
        vb  = bs ? -longint'(bm) : longint'(bm);
        tot = va + vb;
        sgn = (as == bs) ? as : (tot < 0);
        mag = (tot < 0) ? -tot : tot;
        if (mag == 0) begin
            zz  = {sgn, 31'b0};
            lat = -1;
            return;
        end
        k = 0;
        if (mag >= 2**27) begin
            e++;
            sig  = mag >> 4;
            rem  = mag & 15;
            half = 8;
        end else begin
            while (mag < 2**26 && e > -126) begin
                mag = mag * 2;
                e--;
                k++;
            end
            sig  = mag >> 3;
            rem  = mag & 7;
            half = 4;
        end
        if (rem > half || (rem == half && sig[0])) sig++;
        if (sig == 2**24) begin
            sig = 2**23;
            e++;
        end
        if (e > 127)           zz = {sgn, 8'hFF, 23'h0};
        else if (sig < 2**23)  zz = {sgn, 8'h00, 23'(sig)};
        else                   zz = {sgn, 8'(e + 127), 23'(sig)};
        lat = 4 + k;
    endfunction

    task automatic do_op(input logic as, input logic bs, input int e,
                         input logic [26:0] am, input logic [26:0] bm,
                         input logic [31:0] exp_z, input int exp_lat, input int hold);
        int          cyc;
        logic [31:0] z0;
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        a_s = as; b_s = bs; e_in = 10'(e); am_in = am; bm_in = bm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_s = 1'($urandom); b_s = 1'($urandom); e_in = 10'($urandom);
        am_in = 27'($urandom); bm_in = 27'($urandom);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            check_eq("in_ready_busy", in_ready, 0);
            in_valid = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_eq("out_valid_seen", out_valid, 1);
        if (exp_lat >= 0) check_eq("latency", cyc, exp_lat);
        check_eq("z", z, exp_z);
        z0 = z;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_z", z, z0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("handshake_clear", out_valid, 0);
        check_eq("z_keep", z, z0);
        check_eq("in_ready_after", in_ready, 1);
    endtask

    initial begin
        logic        as, bs;
        int          e, lat, seen;
        logic [26:0] am, bm;
        logic [31:0] ez;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_z", z, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", in_ready, 1);

        do_op(1'b0, 1'b0, 0, 27'h4000000, 27'h4000000, 32'h40000000, 4, 0);
        do_op(1'b0, 1'b1, 0, 27'h4000000, 27'h4000000, 32'h00000000, -1, 0);
        do_op(1'b0, 1'b1, 0, 27'h6000000, 27'h4000000, 32'h3F000000, 5, 0);
        do_op(1'b0, 1'b0, 0, 27'h4000004, 27'h0, 32'h3F800000, 4, 0);
        do_op(1'b0, 1'b0, 0, 27'h400000C, 27'h0, 32'h3F800002, 4, 0);
        do_op(1'b0, 1'b0, 127, 27'h4000000, 27'h4000000, 32'h7F800000, 4, 0);
        do_op(1'b1, 1'b1, -126, 27'h0000010, 27'h0000008, 32'h80000003, 4, 1);

        // Reset in the middle of a long normalization.
        @(negedge clk);
        a_s = 1'b0; b_s = 1'b0; e_in = '0; am_in = 27'h1; bm_in = '0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_z", z, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check_eq("midrst_discard", seen, 0);
        do_op(1'b0, 1'b0, 0, 27'h4000000, 27'h4000000, 32'h40000000, 4, 3);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check_eq("single_transfer", seen, 0);

        for (int i = 0; i < 200; i++) begin
            as = 1'($urandom);
            bs = 1'($urandom);
            e  = int'($urandom_range(0, 253)) - 126;
            if (i % 4 == 0) e = -126 + int'($urandom_range(0, 8));
            am = 27'($urandom) >> $urandom_range(0, 26);
            case (i % 3)
                0:       bm = 27'($urandom);
                1:       bm = am ^ 27'($urandom_range(0, 255));
                default: bm = 27'($urandom) >> $urandom_range(0, 26);
            endcase
            model(as, bs, e, am, bm, ez, lat);
            do_op(as, bs, e, am, bm, ez, lat, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
